// File: rtl/dcache_tag_ctrl.sv
// Tag-store controller for the data cache: lookup/compare, dirty marking on store hits,
// refill writes, and a flush sweep that writes back dirty lines and invalidates every index.
module dcache_tag_ctrl #(
   parameter int TAG_WIDTH  = 20,
   parameter int NUM_WORDS  = 256,
   parameter int DATA_WIDTH = TAG_WIDTH + 2,
   parameter int VALID_POS  = TAG_WIDTH + 1,
   parameter int DIRTY_POS  = TAG_WIDTH,
   localparam int IDX_W     = $clog2(NUM_WORDS)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [IDX_W-1:0]      req_index_i,
   input  logic [TAG_WIDTH-1:0]  req_tag_i,
   input  logic                  req_store_i,
   output logic                  rsp_valid_o,
   output logic                  rsp_hit_o,
   output logic                  rsp_victim_dirty_o,
   output logic [TAG_WIDTH-1:0]  rsp_victim_tag_o,
   input  logic                  refill_valid_i,
   input  logic                  flush_i,
   output logic                  flush_busy_o,
   output logic                  flush_done_o,
   output logic                  wb_req_o,
   output logic [IDX_W-1:0]      wb_index_o,
   output logic [TAG_WIDTH-1:0]  wb_tag_o,
   input  logic                  wb_ack_i,
   output logic                  ts_en_o,
   output logic                  ts_we_o,
   output logic [IDX_W-1:0]      ts_addr_o,
   output logic [DATA_WIDTH-1:0] ts_wdata_o,
   output logic [DATA_WIDTH-1:0] ts_bit_en_o,
   input  logic [DATA_WIDTH-1:0] ts_rdata_i
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_LOOKUP     = 3'd1;
   localparam logic [2:0] S_MISS_WAIT  = 3'd2;
   localparam logic [2:0] S_FLUSH_RD   = 3'd3;
   localparam logic [2:0] S_FLUSH_WB   = 3'd4;
   localparam logic [2:0] S_FLUSH_DONE = 3'd5;

   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_WORDS - 1);
   localparam logic [DATA_WIDTH-1:0] BE_DIRTY = DATA_WIDTH'(1) << DIRTY_POS;
   localparam logic [DATA_WIDTH-1:0] BE_VD    = (DATA_WIDTH'(1) << VALID_POS) | BE_DIRTY;

   logic [2:0]           state, state_nxt;
   logic [IDX_W-1:0]     cnt, cnt_nxt;
   logic [IDX_W-1:0]     req_index_p0;
   logic [TAG_WIDTH-1:0] req_tag_p0;
   logic                 req_store_p0;
   logic                 vld_p1;
   logic                 hit_p1;
   logic                 victim_dirty_p1;
   logic [TAG_WIDTH-1:0] victim_tag_p1;
   logic [TAG_WIDTH-1:0] wb_tag_q;
   logic                 rd_valid, rd_dirty, lookup_hit, accept, flush_start;
   logic [TAG_WIDTH-1:0] rd_tag;

   assign rd_valid    = ts_rdata_i[VALID_POS];
   assign rd_dirty    = ts_rdata_i[DIRTY_POS];
   assign rd_tag      = ts_rdata_i[TAG_WIDTH-1:0];
   assign lookup_hit  = rd_valid & (rd_tag == req_tag_p0);
   assign req_ready_o = (state == S_IDLE) & ~flush_i;
   assign accept      = req_valid_i & req_ready_o;
   assign flush_start = (state == S_IDLE) & flush_i;

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      ts_en_o     = 1'b0;
      ts_we_o     = 1'b0;
      ts_addr_o   = cnt;
      ts_wdata_o  = '0;
      ts_bit_en_o = '0;
      case (state)
         S_IDLE: begin
            if (flush_start) begin
               state_nxt = S_FLUSH_RD;
               cnt_nxt   = '0;
            end else if (accept) begin
               state_nxt = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            ts_en_o   = 1'b1;
            ts_addr_o = req_index_p0;
            if (lookup_hit) begin
               if (req_store_p0) begin
                  ts_we_o     = 1'b1;
                  ts_bit_en_o = BE_DIRTY;
                  ts_wdata_o  = BE_DIRTY;
               end
               state_nxt = S_IDLE;
            end else begin
               state_nxt = S_MISS_WAIT;
            end
         end
         S_MISS_WAIT: begin
            ts_addr_o = req_index_p0;
            if (refill_valid_i) begin
               ts_en_o                       = 1'b1;
               ts_we_o                       = 1'b1;
               ts_bit_en_o                   = '1;
               ts_wdata_o[TAG_WIDTH-1:0]     = req_tag_p0;
               ts_wdata_o[DIRTY_POS]         = req_store_p0;
               ts_wdata_o[VALID_POS]         = 1'b1;
               state_nxt                     = S_IDLE;
            end
         end
         S_FLUSH_RD: begin
            ts_en_o = 1'b1;
            if (rd_valid & rd_dirty) begin
               state_nxt = S_FLUSH_WB;
            end else begin
               ts_we_o     = 1'b1;
               ts_bit_en_o = BE_VD;
               if (cnt == LAST_IDX) state_nxt = S_FLUSH_DONE;
               else                 cnt_nxt   = cnt + IDX_W'(1);
            end
         end
         S_FLUSH_WB: begin
            if (wb_ack_i) begin
               ts_en_o     = 1'b1;
               ts_we_o     = 1'b1;
               ts_bit_en_o = BE_VD;
               if (cnt == LAST_IDX) begin
                  state_nxt = S_FLUSH_DONE;
               end else begin
                  cnt_nxt   = cnt + IDX_W'(1);
                  state_nxt = S_FLUSH_RD;
               end
            end
         end
         S_FLUSH_DONE: begin
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // control registers: the only state cleared by reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state  <= S_IDLE;
         cnt    <= '0;
         vld_p1 <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         vld_p1 <= (state == S_LOOKUP);
      end
   end

   // p0: accepted request; p1: lookup result registered for the response pulse
   always_ff @(posedge clk_i) begin
      if (accept) begin
         req_index_p0 <= req_index_i;
         req_tag_p0   <= req_tag_i;
         req_store_p0 <= req_store_i;
      end
      if (state == S_LOOKUP) begin
         hit_p1          <= lookup_hit;
         victim_dirty_p1 <= rd_valid & rd_dirty;
         victim_tag_p1   <= rd_tag;
      end
      if ((state == S_FLUSH_RD) && rd_valid && rd_dirty) wb_tag_q <= rd_tag;
   end

   assign rsp_valid_o        = vld_p1;
   assign rsp_hit_o          = vld_p1 & hit_p1;
   assign rsp_victim_dirty_o = vld_p1 & ~hit_p1 & victim_dirty_p1;
   assign rsp_victim_tag_o   = (vld_p1 & ~hit_p1) ? victim_tag_p1 : '0;

   assign flush_busy_o = (state == S_FLUSH_RD) | (state == S_FLUSH_WB);
   assign flush_done_o = (state == S_FLUSH_DONE);
   assign wb_req_o     = (state == S_FLUSH_WB);
   assign wb_index_o   = wb_req_o ? cnt : '0;
   assign wb_tag_o     = wb_req_o ? wb_tag_q : '0;

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Bench for dcache_tag_ctrl: tag store SRAM model, line-level reference model of the cache
// contents, per-cycle response compare process, directed scenarios plus random traffic.
module tb_dcache_tag_ctrl;
   localparam int TW = 20;
   localparam int NW = 8;
   localparam int DW = TW + 2;
   localparam int IW = 3;

   typedef struct packed {
      logic          v;
      logic          d;
      logic [TW-1:0] tag;
   } line_t;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          req_valid_i = 1'b0;
   logic          req_ready_o;
   logic [IW-1:0] req_index_i = '0;
   logic [TW-1:0] req_tag_i = '0;
   logic          req_store_i = 1'b0;
   logic          rsp_valid_o, rsp_hit_o, rsp_victim_dirty_o;
   logic [TW-1:0] rsp_victim_tag_o;
   logic          refill_valid_i = 1'b0;
   logic          flush_i = 1'b0;
   logic          flush_busy_o, flush_done_o, wb_req_o;
   logic [IW-1:0] wb_index_o;
   logic [TW-1:0] wb_tag_o;
   logic          wb_ack_i = 1'b0;
   logic          ts_en_o, ts_we_o;
   logic [IW-1:0] ts_addr_o;
   logic [DW-1:0] ts_wdata_o, ts_bit_en_o, ts_rdata_i;

   always #5 clk_i = ~clk_i;

   dcache_tag_ctrl #(.TAG_WIDTH(TW), .NUM_WORDS(NW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_index_i(req_index_i),
      .req_tag_i(req_tag_i), .req_store_i(req_store_i),
      .rsp_valid_o(rsp_valid_o), .rsp_hit_o(rsp_hit_o), .rsp_victim_dirty_o(rsp_victim_dirty_o),
      .rsp_victim_tag_o(rsp_victim_tag_o), .refill_valid_i(refill_valid_i),
      .flush_i(flush_i), .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o),
      .wb_req_o(wb_req_o), .wb_index_o(wb_index_o), .wb_tag_o(wb_tag_o), .wb_ack_i(wb_ack_i),
      .ts_en_o(ts_en_o), .ts_we_o(ts_we_o), .ts_addr_o(ts_addr_o), .ts_wdata_o(ts_wdata_o),
      .ts_bit_en_o(ts_bit_en_o), .ts_rdata_i(ts_rdata_i)
   );

   // tag store SRAM: read latched at negedge, bit-masked write at posedge
   logic [DW-1:0] mem [NW];
   logic [DW-1:0] rd_q = '0;
   logic [DW-1:0] last_be = '0;
   int            wr_count = 0;
   logic          pl_en = 1'b0;
   logic [IW-1:0] pl_addr = '0;
   logic [DW-1:0] pl_data = '0;

   always @(posedge clk_i) begin
      if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end else if (ts_en_o && ts_we_o) begin
         mem[ts_addr_o] <= (mem[ts_addr_o] & ~ts_bit_en_o) | (ts_wdata_o & ts_bit_en_o);
         wr_count       <= wr_count + 1;
         last_be        <= ts_bit_en_o;
      end
   end
   always @(negedge clk_i) if (ts_en_o) rd_q <= mem[ts_addr_o];
   assign ts_rdata_i = rd_q;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   // reference model
   line_t         ref_mem [NW];
   int            exp_due [1024];
   logic          exp_hit [1024];
   logic          exp_vd  [1024];
   logic [TW-1:0] exp_vt  [1024];
   int            wr_ptr = 0;
   int            rd_ptr = 0;
   int            seen_wb [$];

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: bound expired (t=%0t)", name, $time);
   endtask

   // per-cycle response compare
   initial begin
      forever begin
         @(negedge clk_i);
         if (rd_ptr < wr_ptr && exp_due[rd_ptr] == cyc) begin
            check("rsp_valid", 64'(rsp_valid_o), 64'(1));
            check("rsp_hit", 64'(rsp_hit_o), 64'(exp_hit[rd_ptr]));
            if (!exp_hit[rd_ptr]) begin
               check("rsp_victim_dirty", 64'(rsp_victim_dirty_o), 64'(exp_vd[rd_ptr]));
               check("rsp_victim_tag", 64'(rsp_victim_tag_o), 64'(exp_vt[rd_ptr]));
            end
            rd_ptr++;
         end else begin
            check("rsp_valid_idle", 64'(rsp_valid_o), 64'(0));
            if (rd_ptr < wr_ptr && exp_due[rd_ptr] < cyc) begin
               fail_now("rsp_missing");
               rd_ptr++;
            end
         end
      end
   end

   task automatic preload(input int a, input line_t l);
      @(negedge clk_i);
      pl_en   = 1'b1;
      pl_addr = IW'(a);
      pl_data = l;
      @(posedge clk_i);
      #1 pl_en = 1'b0;
      ref_mem[a] = l;
   endtask

   task automatic check_mem(input string name, input int a);
      check(name, 64'(mem[a]), 64'(ref_mem[a]));
   endtask

   // request already driven in this half cycle; returns the cycle of acceptance
   task automatic wait_accept(output int acc);
      acc = -1;
      for (int c = 0; c < 300; c++) begin
         #1;
         if (req_ready_o) begin
            @(posedge clk_i);
            #1 acc = cyc;
            req_valid_i = 1'b0;
            break;
         end
         @(negedge clk_i);
      end
      if (acc < 0) begin
         fail_now("accept_timeout");
         req_valid_i = 1'b0;
      end
   endtask

   task automatic expect_rsp(input int idx, input logic [TW-1:0] tag, input int acc, output logic hit);
      line_t l;
      l                 = ref_mem[idx];
      hit               = l.v && (l.tag == tag);
      exp_due[wr_ptr]   = acc + 1;
      exp_hit[wr_ptr]   = hit;
      exp_vd[wr_ptr]    = l.v && l.d;
      exp_vt[wr_ptr]    = l.tag;
      wr_ptr++;
   endtask

   task automatic finish_req(input int idx, input logic [TW-1:0] tag, input logic st,
                             input logic hit, input int dly);
      @(negedge clk_i);
      @(negedge clk_i);
      if (hit) begin
         if (st) ref_mem[idx].d = 1'b1;
      end else begin
         for (int i = 0; i < dly; i++) @(negedge clk_i);
         refill_valid_i = 1'b1;
         @(negedge clk_i);
         refill_valid_i = 1'b0;
         ref_mem[idx] = '{v: 1'b1, d: st, tag: tag};
      end
      check_mem("mem_after_req", idx);
   endtask

   task automatic do_req(input int idx, input logic [TW-1:0] tag, input logic st,
                         input int dly, output logic hit);
      int acc;
      @(negedge clk_i);
      req_valid_i = 1'b1;
      req_index_i = IW'(idx);
      req_tag_i   = tag;
      req_store_i = st;
      wait_accept(acc);
      hit = 1'b0;
      if (acc >= 0) begin
         expect_rsp(idx, tag, acc, hit);
         finish_req(idx, tag, st, hit, dly);
      end
   endtask

   // runs a full flush; with_req holds a request alongside flush_i
   task automatic do_flush(input bit with_req, input int ridx, input logic [TW-1:0] rtag,
                           input int ack_dly);
      int  exp_idx [$];
      int  pos, held, dly;
      bit  pending, done;
      for (int i = 0; i < NW; i++) if (ref_mem[i].v && ref_mem[i].d) exp_idx.push_back(i);
      seen_wb.delete();
      @(negedge clk_i);
      flush_i = 1'b1;
      if (with_req) begin
         req_valid_i = 1'b1;
         req_index_i = IW'(ridx);
         req_tag_i   = rtag;
         req_store_i = 1'b0;
      end
      #1 check("ready_vs_flush", 64'(req_ready_o), 64'(0));
      @(negedge clk_i);
      flush_i = 1'b0;
      pos = 0; held = 0; dly = 0; pending = 1'b0; done = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (c > 0) @(negedge clk_i);
         wb_ack_i = 1'b0;
         if (flush_done_o) begin
            done = 1'b1;
            break;
         end
         if (with_req) check("ready_in_flush", 64'(req_ready_o), 64'(0));
         if (wb_req_o) begin
            check("busy_in_wb", 64'(flush_busy_o), 64'(1));
            if (pos < exp_idx.size()) begin
               check("wb_index", 64'(wb_index_o), 64'(exp_idx[pos]));
               check("wb_tag", 64'(wb_tag_o), 64'(ref_mem[exp_idx[pos]].tag));
            end else begin
               check("wb_unexpected", 64'(wb_req_o), 64'(0));
            end
            if (!pending) begin
               pending = 1'b1;
               held    = 0;
               dly     = (ack_dly >= 0) ? ack_dly : int'($urandom_range(3));
               seen_wb.push_back(int'(wb_index_o));
            end
            if (held == dly) begin
               wb_ack_i = 1'b1;
               pending  = 1'b0;
               pos++;
            end else begin
               held++;
            end
         end else begin
            if (pending) check("wb_req_held", 64'(wb_req_o), 64'(1));
            pending = 1'b0;
            if ($urandom_range(3) == 0) wb_ack_i = 1'b1;
         end
      end
      wb_ack_i = 1'b0;
      if (!done) fail_now("flush_done_timeout");
      check("wb_count", 64'(pos), 64'(exp_idx.size()));
      for (int i = 0; i < NW; i++) begin
         ref_mem[i].v = 1'b0;
         ref_mem[i].d = 1'b0;
      end
      for (int i = 0; i < NW; i++) check_mem("mem_after_flush", i);
      @(negedge clk_i);
      check("flush_done_single", 64'(flush_done_o), 64'(0));
      check("flush_busy_end", 64'(flush_busy_o), 64'(0));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic hit;
      int   acc, wc, got;
      for (int i = 0; i < NW; i++) preload(i, '0);
      check("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
      check("rst_flush_busy", 64'(flush_busy_o), 64'(0));
      check("rst_flush_done", 64'(flush_done_o), 64'(0));
      check("rst_wb_req", 64'(wb_req_o), 64'(0));
      check("rst_ts_en", 64'(ts_en_o), 64'(0));
      check("rst_ts_we", 64'(ts_we_o), 64'(0));
      @(negedge clk_i);
      rst_ni = 1'b1;

      // load miss on empty store, then refill
      do_req(5, TW'('h1A), 1'b0, 1, hit);
      check("t1_hit", 64'(hit), 64'(0));
      check("t1_vdirty", 64'(exp_vd[wr_ptr-1]), 64'(0));
      check("t1_word", 64'(mem[5]), 64'(22'h20001A));
      check("t1_model", 64'(ref_mem[5]), 64'(22'h20001A));

      // store hit writes only the dirty bit
      wc = wr_count;
      do_req(5, TW'('h1A), 1'b1, 0, hit);
      check("t2_hit", 64'(hit), 64'(1));
      check("t2_bit_en", 64'(last_be), 64'(22'h100000));
      check("t2_writes", 64'(wr_count - wc), 64'(1));
      check("t2_word", 64'(mem[5]), 64'(22'h30001A));

      // conflict miss on a dirty line, refilled as a store
      do_req(5, TW'('h2B), 1'b1, 2, hit);
      check("t3_hit", 64'(hit), 64'(0));
      check("t3_vdirty", 64'(exp_vd[wr_ptr-1]), 64'(1));
      check("t3_vtag", 64'(exp_vt[wr_ptr-1]), 64'(TW'('h1A)));
      check("t3_word", 64'(mem[5]), 64'(22'h30002B));

      // flush with dirty lines at 2 and 7, ack held off three cycles
      preload(5, '{v: 1'b1, d: 1'b0, tag: TW'('h2B)});
      preload(2, '{v: 1'b1, d: 1'b1, tag: TW'('h222)});
      preload(7, '{v: 1'b1, d: 1'b1, tag: TW'('h777)});
      preload(3, '{v: 1'b1, d: 1'b0, tag: TW'('h333)});
      do_flush(1'b0, 0, '0, 3);
      check("t4_wb_n", 64'(seen_wb.size()), 64'(2));
      if (seen_wb.size() == 2) begin
         check("t4_wb0", 64'(seen_wb[0]), 64'(2));
         check("t4_wb1", 64'(seen_wb[1]), 64'(7));
      end
      check("t4_word7", 64'(mem[7]), 64'(22'h000777));

      // flush and request in the same cycle: flush wins, request follows
      preload(6, '{v: 1'b1, d: 1'b1, tag: TW'('h66)});
      do_flush(1'b1, 4, TW'('h55), -1);
      wait_accept(acc);
      if (acc >= 0) begin
         expect_rsp(4, TW'('h55), acc, hit);
         check("t5_hit", 64'(hit), 64'(0));
         finish_req(4, TW'('h55), 1'b0, hit, 1);
      end

      // reset while a writeback is outstanding
      preload(2, '{v: 1'b1, d: 1'b1, tag: TW'('h222)});
      preload(7, '{v: 1'b1, d: 1'b1, tag: TW'('h777)});
      @(negedge clk_i);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      got = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk_i);
         if (wb_req_o) begin
            got = 1;
            break;
         end
      end
      if (got == 0) fail_now("t6_wb_wait");
      check("t6_wb_index", 64'(wb_index_o), 64'(2));
      #2 rst_ni = 1'b0;
      #1;
      check("t6_wb_req", 64'(wb_req_o), 64'(0));
      check("t6_busy", 64'(flush_busy_o), 64'(0));
      check("t6_ts_en", 64'(ts_en_o), 64'(0));
      check("t6_wb_tag", 64'(wb_tag_o), 64'(0));
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("t6_idle_ready", 64'(req_ready_o), 64'(1));
      for (int i = 0; i < 2; i++) begin
         ref_mem[i].v = 1'b0;
         ref_mem[i].d = 1'b0;
      end
      for (int i = 0; i < NW; i++) check_mem("t6_mem", i);

      // reset in MISS_WAIT while a refill write is being driven
      @(negedge clk_i);
      req_valid_i = 1'b1;
      req_index_i = IW'(3);
      req_tag_i   = TW'('h99);
      req_store_i = 1'b0;
      wait_accept(acc);
      if (acc >= 0) expect_rsp(3, TW'('h99), acc, hit);
      @(negedge clk_i);
      @(negedge clk_i);
      refill_valid_i = 1'b1;
      #1 check("t7_we_before", 64'(ts_we_o), 64'(1));
      #1 rst_ni = 1'b0;
      #1;
      check("t7_we_async", 64'(ts_we_o), 64'(0));
      check("t7_en_async", 64'(ts_en_o), 64'(0));
      refill_valid_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      wc = wr_count;
      @(negedge clk_i);
      refill_valid_i = 1'b1;
      @(negedge clk_i);
      refill_valid_i = 1'b0;
      @(negedge clk_i);
      check("t7_no_write", 64'(wr_count - wc), 64'(0));
      check_mem("t7_mem", 3);

      // random traffic
      for (int it = 0; it < 250; it++) begin
         int r;
         r = int'($urandom_range(99));
         if (r < 6) begin
            do_flush(1'b0, 0, '0, -1);
         end else if (r < 14) begin
            wc = wr_count;
            @(negedge clk_i);
            refill_valid_i = 1'b1;
            wb_ack_i       = 1'b1;
            @(negedge clk_i);
            refill_valid_i = 1'b0;
            wb_ack_i       = 1'b0;
            @(negedge clk_i);
            check("idle_refill_ignored", 64'(wr_count - wc), 64'(0));
         end else begin
            do_req(int'($urandom_range(NW - 1)), TW'(32'h100 + $urandom_range(3)),
                   1'($urandom_range(1)), int'($urandom_range(3)), hit);
         end
      end
      for (int i = 0; i < NW; i++) check_mem("final_mem", i);
      repeat (3) @(negedge clk_i);
      check("rsp_drained", 64'(wr_ptr - rd_ptr), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
